mem_wb_stage: RTL and testbench

//  MEM stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register.
//  - Performs the data-cache access for loads and stores through a req/ack handshake.
//  - Drives cache_stall back to the EX/MEM register and the upstream stages.
//  - Latches the write-back fields: instruction, regfile write enable/address, write data.

---
 rtl/mem_wb_stage.sv | 134 +++++++++++++
 tb/tb_mem_wb_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage with data-cache req/ack handshake and MEM/WB pipeline register.
// Optional stall counter port enabled by defining MEM_STALL_COUNTER_EN.
module mem_wb_stage #(
  parameter int STALL_CNT_WIDTH = 32,
  parameter bit WORD_ALIGN      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_instruction,
  input  logic        mem_writeRegEnable,
  input  logic [4:0]  mem_writeRegAddr,
  input  logic        mem_mem2Reg,
  input  logic [31:0] mem_aluOutput,
  input  logic        mem_writeMemoryEnable,
  input  logic [31:0] mem_registerRtOrZero,
  output logic        dcReq,
  output logic        dcWe,
  output logic [31:0] dcAddr,
  output logic [31:0] dcWdata,
  input  logic [31:0] dcRdata,
  input  logic        dcAck,
  output logic        cache_stall,
  output logic [31:0] wb_instruction,
  output logic        wb_writeRegEnable,
  output logic [4:0]  wb_writeRegAddr,
  output logic [31:0] wb_writeData
`ifdef MEM_STALL_COUNTER_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stallCycles
`endif
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  if (STALL_CNT_WIDTH < 1) begin : g_bad_width
    $error("STALL_CNT_WIDTH must be at least 1");
  end

  state_t      state;
  state_t      state_n;
  logic        done;
  logic [31:0] loadData;
  logic        access;
  logic        start;
  logic        fin;
  logic [31:0] addr_n;

  assign access      = mem_mem2Reg | mem_writeMemoryEnable;
  assign cache_stall = access & ~done;
  assign addr_n      = WORD_ALIGN ? {mem_aluOutput[31:2], 2'b00}
                                  : mem_aluOutput;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    fin     = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (access && !done) begin
          start   = 1'b1;
          state_n = S_WAIT;
        end
      end
      (state == S_WAIT): begin
        if (dcAck) begin
          fin     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dcReq    <= 1'b0;
      dcWe     <= 1'b0;
      dcAddr   <= '0;
      dcWdata  <= '0;
      done     <= 1'b0;
      loadData <= '0;
    end else begin
      if (start) begin
        dcReq   <= 1'b1;
        dcWe    <= mem_writeMemoryEnable;
        dcAddr  <= addr_n;
        dcWdata <= mem_registerRtOrZero;
      end
      // done lives only until the instruction leaves MEM
      if (!cache_stall) done <= 1'b0;
      if (fin) begin
        dcReq <= 1'b0;
        done  <= 1'b1;
        if (mem_mem2Reg) loadData <= dcRdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_instruction    <= '0;
      wb_writeRegEnable <= 1'b0;
      wb_writeRegAddr   <= '0;
      wb_writeData      <= '0;
    end else if (cache_stall) begin
      wb_instruction    <= '0;
      wb_writeRegEnable <= 1'b0;
      wb_writeRegAddr   <= '0;
      wb_writeData      <= '0;
    end else begin
      wb_instruction    <= mem_instruction;
      wb_writeRegEnable <= mem_writeRegEnable;
      wb_writeRegAddr   <= mem_writeRegAddr;
      wb_writeData      <= mem_mem2Reg ? loadData : mem_aluOutput;
    end
  end

`ifdef MEM_STALL_COUNTER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stallCycles <= '0;
    else if (cache_stall && (stallCycles != '1))
      stallCycles <= stallCycles + STALL_CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed and random
// instructions against a transaction-level model with a bench-side cache.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_instruction;
  logic        mem_writeRegEnable;
  logic [4:0]  mem_writeRegAddr;
  logic        mem_mem2Reg;
  logic [31:0] mem_aluOutput;
  logic        mem_writeMemoryEnable;
  logic [31:0] mem_registerRtOrZero;
  logic        dcReq;
  logic        dcWe;
  logic [31:0] dcAddr;
  logic [31:0] dcWdata;
  logic [31:0] dcRdata;
  logic        dcAck;
  logic        cache_stall;
  logic [31:0] wb_instruction;
  logic        wb_writeRegEnable;
  logic [4:0]  wb_writeRegAddr;
  logic [31:0] wb_writeData;
`ifdef MEM_STALL_COUNTER_EN
  logic [31:0] stallCycles;
`endif

  int compared   = 0;
  int mismatched = 0;
  longint exp_cnt = 0;

  always #5 clock = ~clock;

  mem_wb_stage dut (
    .clock                 (clock),
    .reset                 (reset),
    .mem_instruction       (mem_instruction),
    .mem_writeRegEnable    (mem_writeRegEnable),
    .mem_writeRegAddr      (mem_writeRegAddr),
    .mem_mem2Reg           (mem_mem2Reg),
    .mem_aluOutput         (mem_aluOutput),
    .mem_writeMemoryEnable (mem_writeMemoryEnable),
    .mem_registerRtOrZero  (mem_registerRtOrZero),
    .dcReq                 (dcReq),
    .dcWe                  (dcWe),
    .dcAddr                (dcAddr),
    .dcWdata               (dcWdata),
    .dcRdata               (dcRdata),
    .dcAck                 (dcAck),
    .cache_stall           (cache_stall),
    .wb_instruction        (wb_instruction),
    .wb_writeRegEnable     (wb_writeRegEnable),
    .wb_writeRegAddr       (wb_writeRegAddr),
    .wb_writeData          (wb_writeData)
`ifdef MEM_STALL_COUNTER_EN
    ,
    .stallCycles           (stallCycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble();
    chk("bubble_instr", wb_instruction, 32'h0);
    chk("bubble_wren", {31'h0, wb_writeRegEnable}, 32'h0);
    chk("bubble_wraddr", {27'h0, wb_writeRegAddr}, 32'h0);
    chk("bubble_wdata", wb_writeData, 32'h0);
  endtask

  // Called at a falling edge; returns at the falling edge after WB latched.
  // k = number of dcReq-high cycles before the bench cache acks.
  task automatic run_instr(input logic [31:0] ins, input logic we,
                           input logic [4:0] wa, input logic m2r,
                           input logic [31:0] alu, input logic wme,
                           input logic [31:0] sd, input int k,
                           input logic [31:0] rd);
    logic acc;
    int   stalls;
    int   w;
    logic [31:0] exp_data;
    mem_instruction       = ins;
    mem_writeRegEnable    = we;
    mem_writeRegAddr      = wa;
    mem_mem2Reg           = m2r;
    mem_aluOutput         = alu;
    mem_writeMemoryEnable = wme;
    mem_registerRtOrZero  = sd;
    acc    = m2r | wme;
    stalls = 0;
    w      = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i > 0) chk_bubble();
      if (!cache_stall) break;
      stalls++;
      if (dcReq) begin
        w++;
        chk("dc_addr", dcAddr, alu & 32'hFFFF_FFFC);
        chk("dc_we", {31'h0, dcWe}, {31'h0, wme});
        chk("dc_wdata", dcWdata, sd);
        dcAck   = (w == k);
        dcRdata = (w == k) ? rd : $urandom;
      end else begin
        dcAck   = $urandom_range(0, 1) == 1;
        dcRdata = $urandom;
      end
      @(posedge clock);
      @(negedge clock);
    end
    #1;
    chk("stall_cycles", stalls, acc ? 32'(1 + k) : 32'h0);
    chk("dcreq_idle", {31'h0, dcReq}, 32'h0);
    exp_cnt += stalls == 0 ? 0 : (acc ? 1 + k : 0);
    dcAck   = $urandom_range(0, 1) == 1;
    dcRdata = $urandom;
    @(posedge clock);
    @(negedge clock);
    exp_data = m2r ? rd : alu;
    chk("wb_instr", wb_instruction, ins);
    chk("wb_wren", {31'h0, wb_writeRegEnable}, {31'h0, we});
    chk("wb_wraddr", {27'h0, wb_writeRegAddr}, {27'h0, wa});
    chk("wb_wdata", wb_writeData, exp_data);
    dcAck = 1'b0;
  endtask

  initial begin
    longint base;
    reset = 1'b1;
    mem_instruction = '0; mem_writeRegEnable = 0; mem_writeRegAddr = '0;
    mem_mem2Reg = 0; mem_aluOutput = '0; mem_writeMemoryEnable = 0;
    mem_registerRtOrZero = '0; dcRdata = '0; dcAck = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_dcreq", {31'h0, dcReq}, 32'h0);
    chk("rst_dcaddr", dcAddr, 32'h0);
    chk("rst_stall", {31'h0, cache_stall}, 32'h0);
    chk_bubble();
`ifdef MEM_STALL_COUNTER_EN
    chk("rst_cnt", stallCycles, 32'h0);
`endif
    reset = 1'b0;

    // ALU op, no access
    run_instr(32'h0000_0013, 1, 5, 0, 32'h1234, 0, 32'h0, 0, 32'h0);
    // load at unaligned address, immediate ack
    run_instr(32'h0000_0003, 1, 7, 1, 32'h103, 0, 32'h0, 1, 32'hDEADBEEF);
    // store, ack after five request cycles
    base = exp_cnt;
    run_instr(32'h0000_0023, 0, 0, 0, 32'h200, 1, 32'hCAFE0001, 5, 32'h0);
`ifdef MEM_STALL_COUNTER_EN
    chk("cnt_store", stallCycles, 32'(exp_cnt));
    chk("cnt_delta", 32'(exp_cnt - base), 32'd6);
`endif
    // back-to-back loads
    run_instr(32'h0000_1003, 1, 1, 1, 32'h400, 0, 32'h0, 1, 32'h1111_2222);
    run_instr(32'h0000_2003, 1, 2, 1, 32'h404, 0, 32'h0, 1, 32'h3333_4444);
    // load and store together: store access, load data written back
    run_instr(32'h0000_3003, 1, 3, 1, 32'h50A, 1, 32'h5555, 2, 32'h6666_7777);

    // reset mid-WAIT, then re-request the same load
    mem_instruction = 32'h0000_4003; mem_writeRegEnable = 1;
    mem_writeRegAddr = 9; mem_mem2Reg = 1; mem_aluOutput = 32'h800;
    mem_writeMemoryEnable = 0; mem_registerRtOrZero = 0; dcAck = 0;
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("pre_rst_dcreq", {31'h0, dcReq}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_dcreq", {31'h0, dcReq}, 32'h0);
    chk("async_dcaddr", dcAddr, 32'h0);
    chk_bubble();
    exp_cnt = 0;
    dcAck = 1'b1;
    dcRdata = 32'hBAD0_BAD0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    dcAck = 1'b0;
    run_instr(32'h0000_4003, 1, 9, 1, 32'h800, 0, 32'h0, 3, 32'h0F0F_0F0F);

    // random instruction mix
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_instr($urandom, 1'($urandom), 5'($urandom), kind[0], $urandom,
                kind[1], $urandom, $urandom_range(1, 4), $urandom);
    end
`ifdef MEM_STALL_COUNTER_EN
    chk("cnt_final", stallCycles, 32'(exp_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
